// File: rtl/race_pkg.sv
// Shared definitions for the pulse-race generator and its detector bench:
// FSM state encoding, default parameter values and counter-width helpers.
package race_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } race_gen_state_t;

  localparam int RACE_N_DEF          = 10;
  localparam int RACE_PERIOD_DEF     = 4;
  localparam int RACE_RST_CYCLES_DEF = 2;
  localparam int RACE_LAG_W_DEF      = 8;

  // Bits needed to hold the values 0..n inclusive (never less than 1).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/race_pulse_gen_if.sv
// Request handshake plus race-line outputs of the pulse-race transmitter.
// master = requester / observer side, slave = race_pulse_gen.
interface race_pulse_gen_if #(
  parameter int LAG_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic             req_bit;
  logic [LAG_W-1:0] req_lag;
  logic             pulse_a;
  logic             pulse_b;
  logic             race_rst_n;
  logic             busy;
  logic             done;

  modport master (
    output req_valid, req_bit, req_lag,
    input  req_ready, pulse_a, pulse_b, race_rst_n, busy, done
  );

  modport slave (
    input  req_valid, req_bit, req_lag,
    output req_ready, pulse_a, pulse_b, race_rst_n, busy, done
  );
endinterface

// File: rtl/race_pulse_train.sv
// One race line: after start, waits `delay` cycles, then emits N one-cycle
// pulses spaced PERIOD cycles apart. o_finished rises together with the last
// pulse and stays high until the next start.
module race_pulse_train
  import race_pkg::*;
#(
  parameter int N      = RACE_N_DEF,
  parameter int PERIOD = RACE_PERIOD_DEF,
  parameter int LAG_W  = RACE_LAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [LAG_W-1:0] i_delay,
  output logic             o_pulse,
  output logic             o_finished
);

  localparam int CNT_W = cnt_w(N);
  localparam int GAP_W = max_i(LAG_W, cnt_w(PERIOD));

  logic             r_active;
  logic [GAP_W-1:0] r_gap;       // cycles until next pulse; fires at 1
  logic [CNT_W-1:0] r_cnt;       // pulses emitted so far this frame
  logic             r_pulse;
  logic             r_finished;

  logic             w_fire;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_next;

  // Decide whether a pulse is launched at the coming edge.
  always_comb begin
    w_fire     = 1'b0;
    w_cnt_next = '0;
    if (i_start) begin
      w_fire     = (i_delay == '0);
      w_cnt_next = CNT_W'(1);
    end else begin
      w_fire     = r_active && (r_gap == GAP_W'(1));
      w_cnt_next = r_cnt + CNT_W'(1);
    end
    w_last = w_fire && (w_cnt_next == CNT_W'(N));
  end

  // Gap countdown, pulse counter and registered pulse/finished outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active   <= 1'b0;
      r_gap      <= '0;
      r_cnt      <= '0;
      r_pulse    <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      r_pulse <= w_fire;
      if (w_fire) begin
        r_cnt <= w_cnt_next;
        if (w_last) begin
          r_active   <= 1'b0;
          r_finished <= 1'b1;
        end else begin
          r_active   <= 1'b1;
          r_gap      <= GAP_W'(PERIOD);
          r_finished <= 1'b0;
        end
      end else if (i_start) begin
        r_cnt      <= '0;
        r_active   <= 1'b1;
        r_gap      <= GAP_W'(i_delay);
        r_finished <= 1'b0;
      end else if (r_active && (r_gap > GAP_W'(1))) begin
        // Saturates at 1 so the counter can never wrap inside a frame.
        r_gap <= r_gap - GAP_W'(1);
      end
    end
  end

  assign o_pulse    = r_pulse;
  assign o_finished = r_finished;

endmodule

// File: rtl/race_pulse_gen.sv
// Transmit side of the two-line pulse-race protocol. Each accepted request
// re-arms the detector (race_rst_n low), then races the winner line against
// the loser line, which trails by req_lag cycles, N pulses per line.
module race_pulse_gen
  import race_pkg::*;
#(
  parameter int N          = RACE_N_DEF,
  parameter int PERIOD     = RACE_PERIOD_DEF,
  parameter int RST_CYCLES = RACE_RST_CYCLES_DEF,
  parameter int LAG_W      = RACE_LAG_W_DEF
) (
  input logic             clk,
  input logic             rst,
  race_pulse_gen_if.slave bus
);

  if (N < 1) begin : g_bad_n
    $error("race_pulse_gen: N must be >= 1");
  end
  if (PERIOD < 2) begin : g_bad_period
    $error("race_pulse_gen: PERIOD must be >= 2");
  end
  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("race_pulse_gen: RST_CYCLES must be >= 1");
  end

  localparam int ARM_W = cnt_w(RST_CYCLES);

  race_gen_state_t  r_state;
  race_gen_state_t  w_next;
  logic [ARM_W-1:0] r_arm_cnt;
  logic             r_bit;
  logic [LAG_W-1:0] r_lag;
  logic             r_req_ready;
  logic             r_race_rst_n;
  logic             r_busy;
  logic             r_done;

  logic w_accept;
  logic w_start;
  logic w_win_pulse;
  logic w_win_fin;
  logic w_lose_pulse;
  logic w_lose_fin;

  assign w_accept = (r_state == IDLE) && bus.req_valid && r_req_ready;
  assign w_start  = (r_state == ARM) && (r_arm_cnt == '0);

  // Next-state logic for the frame sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ARM;
      ARM:     if (r_arm_cnt == '0) w_next = RUN;
      RUN:     if (w_win_fin && w_lose_fin) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Counts the re-arm cycles; loaded at accept, reaches zero in the last ARM cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arm_cnt <= '0;
    end else if (w_accept) begin
      r_arm_cnt <= ARM_W'(RST_CYCLES - 1);
    end else if ((r_state == ARM) && (r_arm_cnt != '0)) begin
      r_arm_cnt <= r_arm_cnt - ARM_W'(1);
    end
  end

  // Request fields are captured only at accept; later changes are ignored.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bit <= bus.req_bit;
      r_lag <= bus.req_lag;
    end
  end

  // Control outputs registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ready  <= 1'b0;
      r_race_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_req_ready  <= (w_next == IDLE);
      r_race_rst_n <= (w_next != ARM);
      r_busy       <= (w_next == ARM) || (w_next == RUN);
      r_done       <= (w_next == DONE);
    end
  end

  race_pulse_train #(
    .N      (N),
    .PERIOD (PERIOD),
    .LAG_W  (LAG_W)
  ) u_winner (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_delay    ('0),
    .o_pulse    (w_win_pulse),
    .o_finished (w_win_fin)
  );

  race_pulse_train #(
    .N      (N),
    .PERIOD (PERIOD),
    .LAG_W  (LAG_W)
  ) u_loser (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_delay    (r_lag),
    .o_pulse    (w_lose_pulse),
    .o_finished (w_lose_fin)
  );

  // r_bit only changes at accept, while both trains are quiet.
  assign bus.pulse_a    = r_bit ? w_win_pulse  : w_lose_pulse;
  assign bus.pulse_b    = r_bit ? w_lose_pulse : w_win_pulse;
  assign bus.req_ready  = r_req_ready;
  assign bus.race_rst_n = r_race_rst_n;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_race_pulse_gen.sv
// Directed bench for race_pulse_gen. Cycle offsets are counted from the
// accept cycle T (the cycle in which req_valid and req_ready are both high).
module tb_race_pulse_gen;

  localparam int N          = 10;
  localparam int PERIOD     = 4;
  localparam int RST_CYCLES = 2;
  localparam int LAG_W      = 8;
  localparam int MAXC       = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  race_pulse_gen_if #(.LAG_W(LAG_W)) bus ();

  race_pulse_gen #(
    .N          (N),
    .PERIOD     (PERIOD),
    .RST_CYCLES (RST_CYCLES),
    .LAG_W      (LAG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse expected at offset j on a line starting at T+RST_CYCLES+1+off.
  function automatic int exp_pulse(input int j, input int off);
    int o;
    o = j - (RST_CYCLES + 1) - off;
    return (o >= 0 && (o % PERIOD) == 0 && (o / PERIOD) < N) ? 1 : 0;
  endfunction

  typedef struct {
    logic b;
    int   lag;
    int   first_a;
    int   first_b;
    int   last_a;
    int   last_b;
    int   done_off;
  } vec_t;

  vec_t vecs[6];

  typedef struct {
    int first_a, first_b, last_a, last_b;
    int cnt_a, cnt_b, done_off;
    int rstn_first, rstn_cnt;
    int busy_gap, ready_hi, busy_at_done, ready_after, patt_err;
  } res_t;

  task automatic wait_ready(input string name);
    int w;
    w = 0;
    while (!bus.req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({name, " ready_wait"}, int'(bus.req_ready), 1);
  endtask

  task automatic run_frame(input string name, input logic b, input int lag, output res_t r);
    r = '{first_a: -1, first_b: -1, last_a: -1, last_b: -1, cnt_a: 0, cnt_b: 0,
          done_off: -1, rstn_first: -1, rstn_cnt: 0, busy_gap: 0, ready_hi: 0,
          busy_at_done: -1, ready_after: -1, patt_err: 0};
    @(negedge clk);
    wait_ready(name);
    bus.req_valid = 1'b1;
    bus.req_bit   = b;
    bus.req_lag   = LAG_W'(lag);
    @(posedge clk);
    for (int j = 1; j <= MAXC; j++) begin
      int ea, eb;
      @(negedge clk);
      if (j == 1) bus.req_valid = 1'b0;
      ea = b ? exp_pulse(j, 0) : exp_pulse(j, lag);
      eb = b ? exp_pulse(j, lag) : exp_pulse(j, 0);
      if (int'(bus.pulse_a) != ea || int'(bus.pulse_b) != eb) r.patt_err++;
      if (bus.pulse_a) begin
        if (r.first_a < 0) r.first_a = j;
        r.last_a = j;
        r.cnt_a++;
      end
      if (bus.pulse_b) begin
        if (r.first_b < 0) r.first_b = j;
        r.last_b = j;
        r.cnt_b++;
      end
      if (!bus.race_rst_n) begin
        if (r.rstn_first < 0) r.rstn_first = j;
        r.rstn_cnt++;
      end
      if (bus.req_ready) r.ready_hi++;
      if (bus.done) begin
        r.done_off     = j;
        r.busy_at_done = int'(bus.busy);
        break;
      end
      if (!bus.busy) r.busy_gap++;
    end
    if (r.done_off < 0) begin
      $display("FAIL %s done_timeout: got none, expected done within %0d cycles", name, MAXC);
      n_bad++;
      n_cmp++;
    end else begin
      @(negedge clk);
      r.ready_after = int'(bus.req_ready);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t r;
    int acc1, acc2, done1, done2, viol, cnt_a1, fa1, fb2, fa2;
    int t6_done, t6_pulses;

    vecs[0] = '{b: 1'b1, lag: 2,   first_a: 3,   first_b: 5,  last_a: 39,  last_b: 41, done_off: 42};
    vecs[1] = '{b: 1'b0, lag: 1,   first_a: 4,   first_b: 3,  last_a: 40,  last_b: 39, done_off: 41};
    vecs[2] = '{b: 1'b1, lag: 0,   first_a: 3,   first_b: 3,  last_a: 39,  last_b: 39, done_off: 40};
    vecs[3] = '{b: 1'b1, lag: 9,   first_a: 3,   first_b: 12, last_a: 39,  last_b: 48, done_off: 49};
    vecs[4] = '{b: 1'b0, lag: 0,   first_a: 3,   first_b: 3,  last_a: 39,  last_b: 39, done_off: 40};
    vecs[5] = '{b: 1'b0, lag: 255, first_a: 258, first_b: 3,  last_a: 294, last_b: 39, done_off: 295};

    bus.req_valid = 1'b0;
    bus.req_bit   = 1'b0;
    bus.req_lag   = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst req_ready",  int'(bus.req_ready), 0);
    chk("rst race_rst_n", int'(bus.race_rst_n), 0);
    chk("rst pulse_a",    int'(bus.pulse_a), 0);
    chk("rst pulse_b",    int'(bus.pulse_b), 0);
    chk("rst busy",       int'(bus.busy), 0);
    chk("rst done",       int'(bus.done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready",  int'(bus.req_ready), 1);
    chk("post-rst race_rst_n", int'(bus.race_rst_n), 1);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      run_frame(nm, vecs[i].b, vecs[i].lag, r);
      chk({nm, " first_a"},      r.first_a,      vecs[i].first_a);
      chk({nm, " first_b"},      r.first_b,      vecs[i].first_b);
      chk({nm, " last_a"},       r.last_a,       vecs[i].last_a);
      chk({nm, " last_b"},       r.last_b,       vecs[i].last_b);
      chk({nm, " cnt_a"},        r.cnt_a,        N);
      chk({nm, " cnt_b"},        r.cnt_b,        N);
      chk({nm, " done_off"},     r.done_off,     vecs[i].done_off);
      chk({nm, " rstn_first"},   r.rstn_first,   1);
      chk({nm, " rstn_cnt"},     r.rstn_cnt,     RST_CYCLES);
      chk({nm, " busy_gap"},     r.busy_gap,     0);
      chk({nm, " ready_in_frame"}, r.ready_hi,   0);
      chk({nm, " busy_at_done"}, r.busy_at_done, 0);
      chk({nm, " ready_after"},  r.ready_after,  1);
      chk({nm, " pattern_err"},  r.patt_err,     0);
    end

    // Held req_valid across two frames; fields change mid-frame
    acc1 = -1; acc2 = -1; done1 = -1; done2 = -1; viol = 0;
    cnt_a1 = 0; fa1 = -1; fb2 = -1; fa2 = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.req_valid = 1'b1;
        bus.req_bit   = 1'b1;
        bus.req_lag   = LAG_W'(2);
      end
      if (acc1 >= 0 && c == acc1 + 10) begin
        bus.req_bit = 1'b0;
        bus.req_lag = LAG_W'(9);
      end
      if (bus.busy && bus.req_ready) viol++;
      if (acc1 >= 0 && done1 < 0 && bus.pulse_a) begin
        cnt_a1++;
        if (fa1 < 0) fa1 = c;
      end
      if (acc2 >= 0 && c > acc2) begin
        if (bus.pulse_b && fb2 < 0) fb2 = c;
        if (bus.pulse_a && fa2 < 0) fa2 = c;
      end
      if (bus.done) begin
        if (done1 < 0) done1 = c;
        else begin
          done2 = c;
          break;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        if (acc1 < 0) acc1 = c;
        else if (acc2 < 0) acc2 = c;
      end
    end
    bus.req_valid = 1'b0;
    chk("held done1",       done1 - acc1, 42);
    chk("held accept2",     acc2 - done1, 1);
    chk("held done2",       done2 - acc2, 49);
    chk("held ready_busy",  viol, 0);
    chk("held f1 cnt_a",    cnt_a1, N);
    chk("held f1 first_a",  fa1 - acc1, 3);
    chk("held f2 first_b",  fb2 - acc2, 3);
    chk("held f2 first_a",  fa2 - acc2, 12);

    // Reset at the 5th winner pulse
    @(negedge clk);
    wait_ready("t6");
    bus.req_valid = 1'b1;
    bus.req_bit   = 1'b1;
    bus.req_lag   = LAG_W'(2);
    @(posedge clk);
    for (int j = 1; j <= 19; j++) begin
      @(negedge clk);
      if (j == 1) bus.req_valid = 1'b0;
    end
    chk("t6 5th pulse_a", int'(bus.pulse_a), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6 pulse_a",    int'(bus.pulse_a), 0);
    chk("t6 pulse_b",    int'(bus.pulse_b), 0);
    chk("t6 race_rst_n", int'(bus.race_rst_n), 0);
    chk("t6 done",       int'(bus.done), 0);
    chk("t6 busy",       int'(bus.busy), 0);
    chk("t6 req_ready",  int'(bus.req_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6 rel req_ready",  int'(bus.req_ready), 1);
    chk("t6 rel race_rst_n", int'(bus.race_rst_n), 1);
    t6_done = 0; t6_pulses = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (bus.done) t6_done++;
      if (bus.pulse_a || bus.pulse_b) t6_pulses++;
    end
    chk("t6 no done",   t6_done, 0);
    chk("t6 no pulses", t6_pulses, 0);
    chk("t6 idle ready", int'(bus.req_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
